// File: rtl/bt656cap_pkg.sv
// Shared definitions for the BT.656 capture frame-buffer controller:
// CSR register offsets, CTRL/STAT bit positions and FSM state encoding.
package bt656cap_pkg;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_STAT   = 3'd1;
    localparam logic [2:0] REG_BASE0  = 3'd2;
    localparam logic [2:0] REG_BASE1  = 3'd3;
    localparam logic [2:0] REG_BURSTS = 3'd4;
    localparam logic [2:0] REG_FCOUNT = 3'd5;

    localparam int CTRL_FILT_LSB = 0;
    localparam int CTRL_FILT_MSB = 1;
    localparam int CTRL_DBUF     = 2;
    localparam int CTRL_ONESHOT  = 3;

    localparam int STAT_IN_FRAME = 0;
    localparam int STAT_BUF      = 1;
    localparam int STAT_PENDING  = 2;
    localparam int STAT_DROPPED  = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } fsm_state_t;

endpackage

// File: rtl/bt656cap_burstcnt.sv
// Per-frame burst counter with a registered last-burst flag for the DMA.
module bt656cap_burstcnt (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        start_of_frame,
    input  logic        next_burst,
    input  logic [15:0] bursts,
    output logic        last_burst
);

    logic [15:0] count;
    logic [15:0] count_next;
    logic [15:0] limit;

    // A frame start clears the count even if a burst completes in the same cycle.
    always_comb begin
        count_next = count;
        if (start_of_frame)
            count_next = 16'd0;
        else if (next_burst && count != 16'hFFFF)
            count_next = count + 16'd1;
        limit = (bursts == 16'd0) ? 16'd1 : bursts;
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            count      <= 16'd0;
            last_burst <= 1'b0;
        end else begin
            count      <= count_next;
            last_burst <= (count_next >= limit);
        end
    end

endmodule

// File: rtl/bt656cap_fbctl.sv
// Frame-buffer controller: CSR block plus a per-frame sequencer that steers
// the capture DMA (field filter, buffer base, last burst) and flags frames.
module bt656cap_fbctl
    import bt656cap_pkg::*;
#(
    parameter logic [3:0] csr_addr  = 4'h0,
    parameter int         fml_depth = 27
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic [13:0]          csr_a,
    input  logic                 csr_we,
    input  logic [31:0]          csr_di,
    output logic [31:0]          csr_do,
    output logic                 irq,
    output logic [1:0]           field_filter,
    output logic [fml_depth-6:0] fml_adr_base,
    input  logic                 in_frame,
    input  logic                 start_of_frame,
    input  logic                 next_burst,
    output logic                 last_burst
);

    fsm_state_t           state;
    logic [1:0]           filt;
    logic                 dbuf;
    logic                 oneshot;
    logic                 cur_buf;
    logic                 pending;
    logic                 dropped;
    logic [fml_depth-6:0] base0;
    logic [fml_depth-6:0] base1;
    logic [15:0]          bursts;
    logic [15:0]          fcount;
    logic                 in_frame_q;
    logic                 csr_sel;
    logic                 unused_bits;

    assign csr_sel      = (csr_a[13:10] == csr_addr);
    assign irq          = pending;
    assign field_filter = (state == DONE) ? 2'b00 : filt;
    assign fml_adr_base = cur_buf ? base1 : base0;
    assign unused_bits  = ^{csr_a[9:3], csr_di};

    // DONE-cycle updates come after the CSR write so a frame completion wins
    // over a simultaneous W1C and oneshot still forces filt to zero.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            filt       <= 2'b00;
            dbuf       <= 1'b0;
            oneshot    <= 1'b0;
            cur_buf    <= 1'b0;
            pending    <= 1'b0;
            dropped    <= 1'b0;
            base0      <= '0;
            base1      <= '0;
            bursts     <= 16'd0;
            fcount     <= 16'd0;
            in_frame_q <= 1'b0;
        end else begin
            in_frame_q <= in_frame;

            unique case (state)
                IDLE:    if (start_of_frame) state <= CAPTURE;
                CAPTURE: if (in_frame_q && !in_frame) state <= DONE;
                default: state <= IDLE;
            endcase

            if (csr_sel && csr_we) begin
                case (csr_a[2:0])
                    REG_CTRL: begin
                        filt    <= csr_di[CTRL_FILT_MSB:CTRL_FILT_LSB];
                        dbuf    <= csr_di[CTRL_DBUF];
                        oneshot <= csr_di[CTRL_ONESHOT];
                    end
                    REG_STAT: begin
                        if (csr_di[STAT_PENDING]) pending <= 1'b0;
                        if (csr_di[STAT_DROPPED]) dropped <= 1'b0;
                    end
                    REG_BASE0:  base0  <= csr_di[fml_depth-1:5];
                    REG_BASE1:  base1  <= csr_di[fml_depth-1:5];
                    REG_BURSTS: bursts <= csr_di[15:0];
                    REG_FCOUNT: fcount <= 16'd0;
                    default: ;
                endcase
            end

            if (state == DONE) begin
                fcount <= fcount + 16'd1;
                if (pending)
                    dropped <= 1'b1;
                else
                    pending <= 1'b1;
                if (dbuf)
                    cur_buf <= ~cur_buf;
                if (oneshot)
                    filt <= 2'b00;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            csr_do <= 32'd0;
        end else begin
            csr_do <= 32'd0;
            if (csr_sel) begin
                case (csr_a[2:0])
                    REG_CTRL:   csr_do <= {28'd0, oneshot, dbuf, filt};
                    REG_STAT:   csr_do <= {28'd0, dropped, pending, cur_buf, in_frame};
                    REG_BASE0:  csr_do <= {{(32-fml_depth){1'b0}}, base0, 5'd0};
                    REG_BASE1:  csr_do <= {{(32-fml_depth){1'b0}}, base1, 5'd0};
                    REG_BURSTS: csr_do <= {16'd0, bursts};
                    REG_FCOUNT: csr_do <= {16'd0, fcount};
                    default:    csr_do <= 32'd0;
                endcase
            end
        end
    end

    bt656cap_burstcnt u_burstcnt (
        .sys_clk        (sys_clk),
        .sys_rst_n      (sys_rst_n),
        .start_of_frame (start_of_frame),
        .next_burst     (next_burst),
        .bursts         (bursts),
        .last_burst     (last_burst)
    );

endmodule

// File: tb/tb_bt656cap_fbctl.sv
// Directed bench for bt656cap_fbctl: a CSR write/read-back vector table
// followed by hand-written frame sequences for the multi-cycle corner cases.
module tb_bt656cap_fbctl;
    import bt656cap_pkg::*;

    localparam int FD = 27;

    typedef struct {
        logic        do_write;
        logic [13:0] waddr;
        logic [31:0] wdata;
        logic [13:0] raddr;
        logic [31:0] expect_do;
    } vec_t;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n;
    logic [13:0]   csr_a;
    logic          csr_we;
    logic [31:0]   csr_di;
    logic [31:0]   csr_do;
    logic          irq;
    logic [1:0]    field_filter;
    logic [FD-6:0] fml_adr_base;
    logic          in_frame;
    logic          start_of_frame;
    logic          next_burst;
    logic          last_burst;

    int checks   = 0;
    int failures = 0;
    vec_t vecs[13];

    bt656cap_fbctl #(.csr_addr(4'h0), .fml_depth(FD)) dut (
        .sys_clk        (sys_clk),
        .sys_rst_n      (sys_rst_n),
        .csr_a          (csr_a),
        .csr_we         (csr_we),
        .csr_di         (csr_di),
        .csr_do         (csr_do),
        .irq            (irq),
        .field_filter   (field_filter),
        .fml_adr_base   (fml_adr_base),
        .in_frame       (in_frame),
        .start_of_frame (start_of_frame),
        .next_burst     (next_burst),
        .last_burst     (last_burst)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [13:0] regAddr(input logic [3:0] page, input logic [2:0] r);
        return {page, 7'd0, r};
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s got=0x%08h expected=0x%08h", name, got, want);
        end
    endtask

    task automatic csrWrite(input logic [13:0] addr, input logic [31:0] data);
        csr_a  = addr;
        csr_di = data;
        csr_we = 1'b1;
        tick();
        csr_we = 1'b0;
    endtask

    task automatic csrRead(input logic [13:0] addr, output logic [31:0] data);
        csr_a  = addr;
        csr_we = 1'b0;
        tick();
        data = csr_do;
    endtask

    task automatic applyStimulus(input int idx, input vec_t v);
        logic [31:0] rd;
        if (v.do_write) csrWrite(v.waddr, v.wdata);
        csrRead(v.raddr, rd);
        checkOutput($sformatf("vec%0d", idx), rd, v.expect_do);
    endtask

    // Leaves the caller one cycle into DONE (1 ns after the DONE edge).
    task automatic runFrame();
        in_frame       = 1'b1;
        start_of_frame = 1'b1;
        tick();
        start_of_frame = 1'b0;
        repeat (2) tick();
        in_frame = 1'b0;
        tick();
    endtask

    task automatic doReset();
        sys_rst_n = 1'b0;
        repeat (2) tick();
        sys_rst_n = 1'b1;
        tick();
    endtask

    initial begin
        logic [31:0] rd;

        vecs[0]  = '{1'b1, regAddr(4'h0, REG_BASE0),  32'h0010_0000, regAddr(4'h0, REG_BASE0),  32'h0010_0000};
        vecs[1]  = '{1'b1, regAddr(4'h0, REG_BASE0),  32'hFFFF_FFFF, regAddr(4'h0, REG_BASE0),  32'h07FF_FFE0};
        vecs[2]  = '{1'b1, regAddr(4'h0, REG_BASE1),  32'h0000_001F, regAddr(4'h0, REG_BASE1),  32'h0000_0000};
        vecs[3]  = '{1'b1, regAddr(4'h0, REG_BASE1),  32'h0020_0000, regAddr(4'h0, REG_BASE1),  32'h0020_0000};
        vecs[4]  = '{1'b1, regAddr(4'h0, REG_BURSTS), 32'h0001_2345, regAddr(4'h0, REG_BURSTS), 32'h0000_2345};
        vecs[5]  = '{1'b1, regAddr(4'h0, REG_CTRL),   32'hFFFF_FFFF, regAddr(4'h0, REG_CTRL),   32'h0000_000F};
        vecs[6]  = '{1'b1, regAddr(4'h0, REG_CTRL),   32'h0000_0000, regAddr(4'h0, REG_CTRL),   32'h0000_0000};
        vecs[7]  = '{1'b1, regAddr(4'h0, 3'd6),       32'hFFFF_FFFF, regAddr(4'h0, 3'd6),       32'h0000_0000};
        vecs[8]  = '{1'b1, regAddr(4'h1, REG_BURSTS), 32'h0000_0055, regAddr(4'h0, REG_BURSTS), 32'h0000_2345};
        vecs[9]  = '{1'b0, regAddr(4'h0, REG_CTRL),   32'h0000_0000, regAddr(4'h1, REG_BURSTS), 32'h0000_0000};
        vecs[10] = '{1'b1, regAddr(4'h0, REG_BASE0),  32'h0010_0000, regAddr(4'h0, REG_BASE0),  32'h0010_0000};
        vecs[11] = '{1'b1, regAddr(4'h0, REG_BURSTS), 32'h0000_0003, regAddr(4'h0, REG_BURSTS), 32'h0000_0003};
        vecs[12] = '{1'b1, regAddr(4'h0, 3'd7),       32'hFFFF_FFFF, regAddr(4'h0, 3'd7),       32'h0000_0000};

        sys_rst_n      = 1'b0;
        csr_a          = 14'd0;
        csr_we         = 1'b0;
        csr_di         = 32'd0;
        in_frame       = 1'b0;
        start_of_frame = 1'b0;
        next_burst     = 1'b0;
        repeat (3) tick();
        sys_rst_n = 1'b1;

        checkOutput("rst_irq", 32'(irq), 32'd0);
        checkOutput("rst_field_filter", 32'(field_filter), 32'd0);
        checkOutput("rst_last_burst", 32'(last_burst), 32'd0);
        checkOutput("rst_adr_base", 32'(fml_adr_base), 32'd0);
        for (int r = 0; r < 8; r++) begin
            csrRead(regAddr(4'h0, 3'(r)), rd);
            checkOutput($sformatf("rst_reg%0d", r), rd, 32'd0);
        end

        for (int i = 0; i < 13; i++) applyStimulus(i, vecs[i]);
        checkOutput("adr_base_buf0", 32'(fml_adr_base), 32'h0000_8000);

        // Burst counting with BURSTS = 3
        csrWrite(regAddr(4'h0, REG_CTRL), 32'h1);
        checkOutput("ff_filt01", 32'(field_filter), 32'd1);
        in_frame       = 1'b1;
        start_of_frame = 1'b1;
        tick();
        start_of_frame = 1'b0;
        checkOutput("lb_after_sof", 32'(last_burst), 32'd0);
        for (int p = 1; p <= 3; p++) begin
            next_burst = 1'b1;
            tick();
            next_burst = 1'b0;
            checkOutput($sformatf("lb_pulse%0d", p), 32'(last_burst), (p == 3) ? 32'd1 : 32'd0);
            repeat (3) tick();
        end
        checkOutput("lb_holds", 32'(last_burst), 32'd1);
        start_of_frame = 1'b1;
        next_burst     = 1'b1;
        tick();
        start_of_frame = 1'b0;
        next_burst     = 1'b0;
        checkOutput("lb_sof_clear_wins", 32'(last_burst), 32'd0);
        in_frame = 1'b0;
        repeat (2) tick();
        checkOutput("irq_frame_done", 32'(irq), 32'd1);
        doReset();
        checkOutput("irq_after_reset", 32'(irq), 32'd0);

        // Double buffering across two frames
        csrWrite(regAddr(4'h0, REG_BASE0), 32'h0010_0000);
        csrWrite(regAddr(4'h0, REG_BASE1), 32'h0020_0000);
        csrWrite(regAddr(4'h0, REG_CTRL),  32'h5);
        checkOutput("db_base_initial", 32'(fml_adr_base), 32'h0000_8000);
        runFrame();
        checkOutput("db_done_irq", 32'(irq), 32'd0);
        checkOutput("db_done_ff", 32'(field_filter), 32'd0);
        checkOutput("db_done_base", 32'(fml_adr_base), 32'h0000_8000);
        tick();
        checkOutput("db_f1_irq", 32'(irq), 32'd1);
        checkOutput("db_f1_base", 32'(fml_adr_base), 32'h0001_0000);
        checkOutput("db_f1_ff", 32'(field_filter), 32'd1);
        runFrame();
        tick();
        checkOutput("db_f2_base", 32'(fml_adr_base), 32'h0000_8000);
        csrRead(regAddr(4'h0, REG_FCOUNT), rd);
        checkOutput("db_fcount", rd, 32'd2);
        csrRead(regAddr(4'h0, REG_STAT), rd);
        checkOutput("db_stat", rd, 32'h0000_000C);
        csrWrite(regAddr(4'h0, REG_STAT), 32'hC);
        checkOutput("w1c_irq_clear", 32'(irq), 32'd0);

        // W1C of pending in the DONE cycle loses to the set
        runFrame();
        csrWrite(regAddr(4'h0, REG_STAT), 32'h4);
        checkOutput("w1c_in_done", 32'(irq), 32'd1);
        csrWrite(regAddr(4'h0, REG_STAT), 32'h4);
        checkOutput("w1c_after_done", 32'(irq), 32'd0);
        checkOutput("f3_base", 32'(fml_adr_base), 32'h0001_0000);
        csrRead(regAddr(4'h0, REG_STAT), rd);
        checkOutput("f3_stat", rd, 32'h0000_0002);
        csrRead(regAddr(4'h0, REG_FCOUNT), rd);
        checkOutput("f3_fcount", rd, 32'd3);
        csrWrite(regAddr(4'h0, REG_FCOUNT), 32'h1234);
        csrRead(regAddr(4'h0, REG_FCOUNT), rd);
        checkOutput("fcount_clear", rd, 32'd0);

        // Oneshot capture
        csrWrite(regAddr(4'h0, REG_CTRL), 32'hB);
        checkOutput("os_ff_before", 32'(field_filter), 32'd3);
        runFrame();
        checkOutput("os_ff_done", 32'(field_filter), 32'd0);
        tick();
        checkOutput("os_ff_after", 32'(field_filter), 32'd0);
        csrRead(regAddr(4'h0, REG_CTRL), rd);
        checkOutput("os_ctrl", rd, 32'h0000_0008);
        in_frame = 1'b1;
        repeat (4) tick();
        in_frame = 1'b0;
        repeat (3) tick();
        csrRead(regAddr(4'h0, REG_FCOUNT), rd);
        checkOutput("os_fcount", rd, 32'd1);

        // CTRL write in the DONE cycle: written value kept, filt forced to 0
        csrWrite(regAddr(4'h0, REG_CTRL), 32'hB);
        runFrame();
        csrWrite(regAddr(4'h0, REG_CTRL), 32'h7);
        csrRead(regAddr(4'h0, REG_CTRL), rd);
        checkOutput("ctrl_in_done", rd, 32'h0000_0004);
        csrRead(regAddr(4'h0, REG_FCOUNT), rd);
        checkOutput("ctrl_fcount", rd, 32'd2);

        // BURSTS = 0 acts as 1, then reset mid-capture
        csrWrite(regAddr(4'h0, REG_BURSTS), 32'h0);
        csrWrite(regAddr(4'h0, REG_CTRL), 32'h1);
        in_frame       = 1'b1;
        start_of_frame = 1'b1;
        tick();
        start_of_frame = 1'b0;
        checkOutput("b0_lb_sof", 32'(last_burst), 32'd0);
        next_burst = 1'b1;
        tick();
        next_burst = 1'b0;
        checkOutput("b0_lb_first", 32'(last_burst), 32'd1);
        checkOutput("pre_rst_irq", 32'(irq), 32'd1);
        checkOutput("pre_rst_base", 32'(fml_adr_base), 32'h0001_0000);
        csrRead(regAddr(4'h0, REG_BASE1), rd);
        checkOutput("pre_rst_do", rd, 32'h0020_0000);
        sys_rst_n = 1'b0;
        tick();
        checkOutput("mid_rst_irq", 32'(irq), 32'd0);
        checkOutput("mid_rst_ff", 32'(field_filter), 32'd0);
        checkOutput("mid_rst_lb", 32'(last_burst), 32'd0);
        checkOutput("mid_rst_base", 32'(fml_adr_base), 32'd0);
        checkOutput("mid_rst_do", csr_do, 32'd0);
        in_frame  = 1'b0;
        sys_rst_n = 1'b1;
        tick();
        csrRead(regAddr(4'h0, REG_CTRL), rd);
        checkOutput("post_rst_ctrl", rd, 32'd0);
        csrRead(regAddr(4'h0, REG_FCOUNT), rd);
        checkOutput("post_rst_fcount", rd, 32'd0);
        csrRead(regAddr(4'h0, REG_STAT), rd);
        checkOutput("post_rst_stat", rd, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bt656cap_fbctl.md
# bt656cap_fbctl

Frame-buffer controller for the BT.656 capture path: owns the CSR-visible capture configuration and sequences the capture DMA engine frame by frame. Supplies the DMA with field filter, burst base address and end-of-frame (last burst) indication. Manages single or ping-pong double buffering, counts completed frames and raises a level interrupt per completed frame. Sits between the CSR bus and the capture DMA engine; has no FML or video ports of its own.

## Interface
- csr_addr, 4'h0: CSR page select, matched against csr_a[13:10]
- fml_depth, 27: FML byte-address width; burst addresses are fml_depth-5 bits
- sys_clk  in  1  system clock; every register updates on its rising edge
- sys_rst_n  in  1  synchronous, active-low reset
- csr_a  in  14  CSR address; [13:10] page, [2:0] register
- csr_we  in  1  CSR write strobe
- csr_di  in  32  CSR write data
- csr_do  out  32  CSR read data, registered
- irq  out  1  level interrupt = frame-pending flag
- field_filter  out  2  to DMA; bit0 captures frames starting on field 1→0, bit1 on field 0→1; 0 = no new frame starts
- fml_adr_base  out  fml_depth-5  to DMA; burst base of the buffer the next frame is written to
- in_frame  in  1  from DMA; high while a frame is being written
- start_of_frame  in  1  from DMA; 1-cycle pulse at accepted frame start
- next_burst  in  1  from DMA; 1-cycle pulse per burst written
- last_burst  out  1  to DMA; high when the current burst is the last of the frame

## Operation
- Registers (offset = csr_a[2:0]):
  - 0 CTRL: [1:0] filt, [2] dbuf, [3] oneshot
  - 1 STAT: [0] in_frame (RO), [1] buf (RO), [2] pending (W1C), [3] dropped (W1C)
  - 2 BASE0: byte address, bits [fml_depth-1:5]; [4:0] read 0
  - 3 BASE1: same layout as BASE0
  - 4 BURSTS: [15:0] bursts per frame
  - 5 FCOUNT: [15:0] completed frames; any write clears it
  - 6, 7: read 0
- Reset values: CTRL 0, buf 0, pending 0, dropped 0, BASE0/BASE1 0, BURSTS 0, FCOUNT 0. Outputs: csr_do 0, irq 0, field_filter 0, last_burst 0, fml_adr_base 0.
- field_filter = CTRL.filt while not in state DONE. Clearing filt mid-frame lets the current frame finish and blocks the next one.
- fml_adr_base = buf ? BASE1[..5] : BASE0[..5]. It changes only in DONE, so it is stable across every start_of_frame.
- Burst counter: 16 bits. Cleared on start_of_frame and incremented on next_burst. If both pulse in the same cycle, the clear wins.
- last_burst is registered: (count+inc) ≥ max(BURSTS,1), evaluated each cycle. BURSTS = 0 behaves as 1. The counter saturates at 16'hFFFF.
- FSM states:
  - IDLE → CAPTURE on start_of_frame.
  - CAPTURE → DONE on in_frame falling (registered in_frame 1, current 0).
  - DONE lasts 1 cycle, then → IDLE.
- Actions in DONE:
  - FCOUNT+1, wrapping modulo 2^16.
  - If pending is already 1, set dropped; otherwise set pending.
  - If dbuf, toggle buf.
  - If oneshot, clear CTRL.filt.
- Simultaneous events:
  - Software W1C of pending in the DONE cycle: the DONE set wins.
  - Software write to CTRL in the DONE cycle: the written value wins, except that oneshot clearing still forces filt = 0.
- dbuf = 0: buf holds its value. Software toggles buffers by rewriting BASE0.
- Reset asserted mid-frame returns every register to its reset value. The DMA is reset by the same sys_rst_n.

## Timing
- CSR read: csr_do valid 1 cycle after csr_a. csr_do is 0 when the page does not match.
- CSR write: takes effect on the sys_clk edge where csr_we is sampled.
- End of frame: in_frame falls at edge N. DONE is at N+1. irq, buf, fml_adr_base and FCOUNT update at edge N+2.
- last_burst: valid 1 cycle after next_burst. The DMA samples it 2 cycles after next_burst.
- The minimum gap from DONE to the next accepted start_of_frame is 1 cycle.

## Structure
- Shared package bt656cap_pkg holds the register offsets (CTRL, STAT, BASE0, BASE1, BURSTS, FCOUNT), the CTRL/STAT bit positions and the FSM state encoding (IDLE, CAPTURE, DONE).
- One natural sub-module: bt656cap_burstcnt, the burst counter plus registered last_burst comparator.

## Test plan
- Reset then read all registers → every register reads 0, irq = 0, field_filter = 0.
- BURSTS = 3, filt = 2'b01, pulse start_of_frame, then 3 next_burst pulses 4 cycles apart → last_burst high only after the 3rd pulse; count cleared by the next start_of_frame.
- dbuf = 1, BASE0 = 0x100000, BASE1 = 0x200000; complete two frames (in_frame high then low) → fml_adr_base goes 0x8000, then 0x10000, then 0x8000; FCOUNT = 2; dropped = 1; irq = 1.
- Write STAT = 0x4 in the DONE cycle → pending stays 1. Write STAT = 0x4 one cycle later → irq = 0.
- oneshot = 1, filt = 2'b11; complete one frame → filt reads 0 and field_filter = 0 at N+2; a subsequent in_frame pulse does not increment FCOUNT.
- BURSTS = 0 → last_burst high after the 1st next_burst. Drop sys_rst_n mid-capture → all outputs 0 on the next edge.
